// File: rtl/enc4to2_if.sv
// ---------------------------------------------------------------------------
// enc4to2_if
// Bundles the two valid/ready channels of the registered 4:2 encoder.
//
// Input side  : d[0:3], d_valid, d_ready
// Output side : a, b, multi, none, out_valid, out_ready
// err_cnt     : present only when ENC_ERR_CNT_EN is defined
//
// Modports
//   slave  - the encoder (consumes d, produces the code)
//   master - the environment (drives d and out_ready, observes results)
//
// Configuration macro: ENC_ERR_CNT_EN
// ---------------------------------------------------------------------------
interface enc4to2_if #(
    parameter int unsigned CNT_W = 8
);
    logic [0:3]       d;
    logic             d_valid;
    logic             d_ready;
    logic             a;
    logic             b;
    logic             out_valid;
    logic             out_ready;
    logic             multi;
    logic             none;
`ifdef ENC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    // A zero-width counter is meaningless.
    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("enc4to2_if: CNT_W must be at least 1");
    end

`ifdef ENC_ERR_CNT_EN
    modport slave (
        input  d, d_valid, out_ready,
        output d_ready, a, b, out_valid, multi, none, err_cnt
    );
    modport master (
        output d, d_valid, out_ready,
        input  d_ready, a, b, out_valid, multi, none, err_cnt
    );
`else
    modport slave (
        input  d, d_valid, out_ready,
        output d_ready, a, b, out_valid, multi, none
    );
    modport master (
        output d, d_valid, out_ready,
        input  d_ready, a, b, out_valid, multi, none
    );
`endif
endinterface

// File: rtl/enc4to2_reg.sv
// ---------------------------------------------------------------------------
// enc4to2_reg
// Registered 4:2 priority encoder with a one-entry output buffer. The highest
// set line wins, and inputs that are not one-hot are flagged. It is the
// inverse of the 2:4 decoder.
//
// Ports
//   clk      in  clock, rising edge
//   rst      in  asynchronous, active-high reset; drops any held result
//   enc_if   slave modport of enc4to2_if:
//              d[0:3], d_valid -> d_ready      (input channel)
//              a, b, multi, none, out_valid <- out_ready (output channel)
//              err_cnt (ENC_ERR_CNT_EN only)
//
// Parameter
//   CNT_W    width of the saturating error counter (ENC_ERR_CNT_EN only)
//
// Configuration macro: ENC_ERR_CNT_EN
//   Defined     - err_cnt counts accepts with multi or none set. It saturates
//                 and does not wrap.
//   Not defined - there is no counter and no err_cnt signal.
// ---------------------------------------------------------------------------
module enc4to2_reg #(
    parameter int unsigned CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    enc4to2_if.slave  enc_if
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic multi;
        logic none;
    } res_t;

    state_e state_q, state_d;
    res_t   res_q, res_d;
    res_t   enc;
    logic   load;

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("enc4to2_reg: CNT_W must be at least 1");
    end

    // Combinational encode of the presented line vector.
    always_comb begin
        logic [2:0] pop;
        enc = '0;
        pop = 3'(enc_if.d[0]) + 3'(enc_if.d[1]) + 3'(enc_if.d[2]) + 3'(enc_if.d[3]);
        if (enc_if.d[3])      {enc.a, enc.b} = 2'b11;
        else if (enc_if.d[2]) {enc.a, enc.b} = 2'b10;
        else if (enc_if.d[1]) {enc.a, enc.b} = 2'b01;
        else                  {enc.a, enc.b} = 2'b00;   // d[0] or all zero
        enc.multi = (pop >= 3'd2);
        enc.none  = (pop == 3'd0);
    end

    // Next state and handshake. d_ready depends only on state and
    // out_ready, so it has no path from d_valid.
    always_comb begin
        state_d        = state_q;
        enc_if.d_ready = 1'b0;
        load           = 1'b0;
        unique case (state_q)
            EMPTY: begin
                enc_if.d_ready = 1'b1;
                if (enc_if.d_valid) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                enc_if.d_ready = enc_if.out_ready;
                if (enc_if.out_ready) begin
                    // Back-to-back refill avoids a bubble.
                    load    = enc_if.d_valid;
                    state_d = enc_if.d_valid ? FULL : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        res_d = load ? enc : res_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign enc_if.out_valid = (state_q == FULL);
    assign enc_if.a         = res_q.a;
    assign enc_if.b         = res_q.b;
    assign enc_if.multi     = res_q.multi;
    assign enc_if.none      = res_q.none;

`ifdef ENC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (load && (enc.multi || enc.none) && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign enc_if.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_enc4to2_reg.sv
// Directed bench for enc4to2_reg. Inputs change 1 ns after a rising edge, and
// results are checked before the next edge.
module tb_enc4to2_reg;
`ifdef ENC_ERR_CNT_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    enc4to2_if #(.CNT_W(CNT_W)) bus ();

    enc4to2_reg #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enc_if (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result word packed as {out_valid, a, b, multi, none}.
    function automatic logic [7:0] res();
        return {3'b000, bus.out_valid, bus.a, bus.b, bus.multi, bus.none};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.d         = 4'b0000;
        bus.d_valid   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        chk("reset_res",    res(),       8'h00);
        chk("reset_dready", bus.d_ready, 8'h01);
        step();
        step();
        rst = 1'b0;

        // One-hot sweep, back-to-back (d[0] is the leftmost literal bit)
        bus.out_ready = 1'b1;
        bus.d_valid   = 1'b1;
        bus.d         = 4'b1000;
        #1;
        chk("sweep_dready", bus.d_ready, 8'h01);
        step(); chk("sweep_00", res(), 8'b1_00_00);
        bus.d = 4'b0100;
        step(); chk("sweep_01", res(), 8'b1_01_00);
        bus.d = 4'b0010;
        step(); chk("sweep_10", res(), 8'b1_10_00);
        bus.d = 4'b0001;
        step(); chk("sweep_11", res(), 8'b1_11_00);

        // Non-one-hot inputs
        bus.d = 4'b0110;
        step(); chk("multi_0110", res(), 8'b1_10_10);
        bus.d = 4'b0000;
        step(); chk("none_0000",  res(), 8'b1_00_01);
        bus.d = 4'b1100;
        step(); chk("multi_1100", res(), 8'b1_01_10);
        bus.d = 4'b0011;
        step(); chk("multi_0011", res(), 8'b1_11_10);

        // Backpressure: hold {a,b}=11 for 5 cycles while offering d=1000
        bus.d = 4'b0001;
        step(); chk("bp_load", res(), 8'b1_11_00);
        bus.out_ready = 1'b0;
        bus.d         = 4'b1000;
        #1;
        chk("bp_dready0", bus.d_ready, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold",   res(),       8'b1_11_00);
            chk("bp_dready", bus.d_ready, 8'h00);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_dready", bus.d_ready, 8'h01);
        step(); chk("bp_release", res(), 8'b1_00_00);

        // Drain to EMPTY. d_ready in EMPTY does not depend on out_ready.
        bus.d_valid = 1'b0;
        step(); chk("drain_empty", bus.out_valid, 8'h00);
        bus.out_ready = 1'b0;
        #1;
        chk("empty_dready", bus.d_ready, 8'h01);
        bus.d_valid = 1'b1;
        bus.d       = 4'b0010;
        step(); chk("empty_load", res(), 8'b1_10_00);
        bus.d_valid = 1'b0;
        step(); chk("full_hold_nodv", res(), 8'b1_10_00);

        // Asynchronous reset while holding a result
        bus.out_ready = 1'b1;
        bus.d_valid   = 1'b1;
        bus.d         = 4'b1111;
        step(); chk("pre_rst", res(), 8'b1_11_10);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", res(), 8'h00);
`ifdef ENC_ERR_CNT_EN
        chk("async_rst_cnt", 8'(bus.err_cnt), 8'h00);
`endif
        bus.d_valid = 1'b0;
        step();
        rst = 1'b0;

        // Repeated all-ones accepts. The counter (when present) saturates at 3.
        bus.d_valid = 1'b1;
        bus.d       = 4'b1111;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("ones_res", res(), 8'b1_11_10);
`ifdef ENC_ERR_CNT_EN
            chk("err_cnt", 8'(bus.err_cnt), 8'((i > 3) ? 3 : i));
`endif
        end
        bus.d_valid = 1'b0;
        step(); chk("final_empty", bus.out_valid, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
